// File: rtl/pin_lock_pkg.sv
// Shared definitions for the push-button front end and the pin-code tester:
// key count, debounce default, decoder FSM encoding and key-to-digit mapping.
package pin_lock_pkg;

    localparam int NUM_KEYS         = 4;
    // 10 ms at 50 MHz
    localparam int DEBOUNCE_DEFAULT = 500000;

    localparam logic [NUM_KEYS-1:0] KEY_NONE = '0;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_PRESS_WAIT   = 3'd1,
        ST_PRESSED      = 3'd2,
        ST_HELD         = 3'd3,
        ST_RELEASE_WAIT = 3'd4
    } key_state_t;

    // One-hot key to digit: key[0] -> 1, key[1] -> 2, ...; no key -> 0.
    function automatic logic [3:0] key_to_digit(input logic [NUM_KEYS-1:0] k);
        logic [3:0] d;
        d = 4'd0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (k[i]) d = 4'(i + 1);
        end
        return d;
    endfunction

endpackage

// File: rtl/key_synchroniser.sv
// Two-flop synchroniser for the raw, active-low button levels. Flops reset to
// the released level so a reset never looks like a press; the output is
// inverted so downstream logic sees 1 = pressed.
module key_synchroniser #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] pressed
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;

    // Two-stage metastability filter, released (all ones) in reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign pressed = ~sync2;

endmodule

// File: rtl/key_press_decoder.sv
// Debounces the push buttons and emits one registered, one-cycle, one-hot key
// pulse per physical press. A single shared FSM serves all keys, so chords,
// bounce and long holds never produce duplicate or ambiguous pulses.
module key_press_decoder #(
    parameter int NUM_KEYS        = pin_lock_pkg::NUM_KEYS,
    parameter int DEBOUNCE_CYCLES = pin_lock_pkg::DEBOUNCE_DEFAULT,
    parameter int COUNTER_WIDTH   = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keyRaw,
    output logic [NUM_KEYS-1:0] key,
    output logic                busy
);

    import pin_lock_pkg::*;

    localparam logic [COUNTER_WIDTH-1:0] CNT_LAST = COUNTER_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0]      pressed;
    logic                     one_hot;
    key_state_t               state;
    key_state_t               next_state;
    logic [COUNTER_WIDTH-1:0] cnt;
    logic [COUNTER_WIDTH-1:0] cnt_nxt;
    logic [NUM_KEYS-1:0]      key_sel;
    logic [NUM_KEYS-1:0]      key_sel_nxt;
    logic [NUM_KEYS-1:0]      key_nxt;
    logic                     busy_nxt;

    key_synchroniser #(
        .WIDTH(NUM_KEYS)
    ) u_sync (
        .clock  (clock),
        .reset  (reset),
        .raw    (keyRaw),
        .pressed(pressed)
    );

    // Exactly one key down; chords and no-key are both rejected.
    assign one_hot = (pressed != '0) && ((pressed & (pressed - 1'b1)) == '0);

    // FSM state, debounce counter and captured key.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            key_sel <= '0;
        end else begin
            state   <= next_state;
            cnt     <= cnt_nxt;
            key_sel <= key_sel_nxt;
        end
    end

    // Next state: counter saturates at CNT_LAST because the FSM leaves on it.
    always_comb begin
        next_state  = state;
        cnt_nxt     = cnt;
        key_sel_nxt = key_sel;
        case (state)
            ST_IDLE: begin
                if (one_hot) begin
                    key_sel_nxt = pressed;
                    cnt_nxt     = '0;
                    next_state  = ST_PRESS_WAIT;
                end
            end
            ST_PRESS_WAIT: begin
                if (pressed == key_sel) begin
                    if (cnt == CNT_LAST) next_state = ST_PRESSED;
                    else                 cnt_nxt    = cnt + 1'b1;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_PRESSED: begin
                next_state = ST_HELD;
            end
            ST_HELD: begin
                // Extra keys here are ignored; only a full release moves on.
                if (pressed == '0) begin
                    cnt_nxt    = '0;
                    next_state = ST_RELEASE_WAIT;
                end
            end
            ST_RELEASE_WAIT: begin
                if (pressed == '0) begin
                    if (cnt == CNT_LAST) next_state = ST_IDLE;
                    else                 cnt_nxt    = cnt + 1'b1;
                end else begin
                    next_state = ST_HELD;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Outputs derived from the next state so they register with the transition.
    always_comb begin
        key_nxt  = (next_state == ST_PRESSED) ? key_sel : '0;
        busy_nxt = (next_state != ST_IDLE);
    end

    // Registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            key  <= '0;
            busy <= 1'b0;
        end else begin
            key  <= key_nxt;
            busy <= busy_nxt;
        end
    end

endmodule
